instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 25 ++
 rtl/instruction_fetch_unit_if.sv | 29 ++
 rtl/instruction_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM encoding and the reset/flush defaults.
package instruction_fetch_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } fetch_state_e;

  localparam word_t RESET_PC_DEF  = 32'h0040_0000;
  localparam word_t NOP_INSTR_DEF = 32'h0000_0013;

  function automatic word_t pc_inc(input word_t pc);
    return pc + 32'd4;
  endfunction

  function automatic word_t word_align(input word_t a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response bus.
// master = fetch unit, slave = memory.
interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
();

  logic  imem_req;
  word_t imem_addr;
  logic  imem_gnt;
  logic  imem_rvalid;
  word_t imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register, one-outstanding imem FSM,
// stall hold buffer and redirect flush feeding IF/ID.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEF,
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  instruction_fetch_unit_if.master imem,
  output word_t instruction_out,
  output word_t pc_out,
  output word_t pc_plus_4_out,
  output logic  valid_out
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        hold_q, hold_d;
  word_t        instr_q, instr_d;
  word_t        pco_q, pco_d;
  word_t        pcp4_q, pcp4_d;
  logic         valid_q, valid_d;

  logic         load;
  word_t        load_data;
  logic         pending;

  // A request is still in flight if it was just granted
  // or its response has not yet come back.
  assign pending =
    (state_q == S_REQ  &&  imem.imem_gnt)    ||
    (state_q == S_WAIT && !imem.imem_rvalid) ||
    (state_q == S_DROP && !imem.imem_rvalid);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    instr_d   = instr_q;
    pco_d     = pco_q;
    pcp4_d    = pcp4_q;
    valid_d   = stall ? valid_q : 1'b0;
    load      = 1'b0;
    load_data = hold_q;

    unique case (state_q)
      S_REQ: begin
        if (imem.imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (stall) begin
            hold_d  = imem.imem_rdata;
            state_d = S_HOLD;
          end else begin
            load      = 1'b1;
            load_data = imem.imem_rdata;
            state_d   = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          load    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem.imem_rvalid) state_d = S_REQ;
      end
    endcase

    if (redirect) begin
      pc_d    = word_align(redirect_pc);
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      hold_d  = '0;
      state_d = pending ? S_DROP : S_REQ;
    end else if (load) begin
      instr_d = load_data;
      pco_d   = pc_q;
      pcp4_d  = pc_inc(pc_q);
      valid_d = 1'b1;
      pc_d    = pc_inc(pc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      instr_q <= '0;
      pco_q   <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pco_q   <= pco_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign imem.imem_req  = (state_q == S_REQ) && !reset;
  assign imem.imem_addr = pc_q;

  assign instruction_out = instr_q;
  assign pc_out          = pco_q;
  assign pc_plus_4_out   = pcp4_q;
  assign valid_out       = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a
// latency-programmable memory model and fetch scoreboard.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  word_t instruction_out;
  word_t pc_out;
  word_t pc_plus_4_out;
  logic  valid_out;

  instruction_fetch_unit_if mem();

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem            (mem),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .pc_plus_4_out   (pc_plus_4_out),
    .valid_out       (valid_out)
  );

  always #5 clk = ~clk;

  exp_t  sb[$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    lat     = 1;
  int    cnt     = 0;
  word_t pdata   = '0;
  logic  live    = 1'b0;
  word_t live_addr = '0;
  word_t ovr_addr  = 32'h0000_0001;
  word_t ovr_data  = '0;

  function automatic word_t mem_word(input word_t a);
    return (a == ovr_addr) ? ovr_data : ~a;
  endfunction

  task automatic chk(input string tag, input word_t obs,
                     input word_t exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cycle();
    logic  fire;
    logic  st;
    word_t a;
    exp_t  e;
    fire = mem.imem_req && mem.imem_gnt && !reset;
    a    = mem.imem_addr;
    st   = stall;
    if (mem.imem_rvalid) begin
      if (live && !redirect && !reset)
        sb.push_back('{instr: mem.imem_rdata, pc: live_addr});
      live = 1'b0;
    end
    if (redirect || reset) live = 1'b0;
    if (fire && !redirect) begin
      live      = 1'b1;
      live_addr = a;
    end
    @(posedge clk);
    #1;
    mem.imem_rvalid = 1'b0;
    if (fire) begin
      cnt   = lat;
      pdata = mem_word(a);
    end
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mem.imem_rvalid = 1'b1;
        mem.imem_rdata  = pdata;
      end
    end
    if (!st && valid_out === 1'b1) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_instr", instruction_out, e.instr);
        chk("sb_pc", pc_out, e.pc);
        chk("sb_pc4", pc_plus_4_out, e.pc + 32'd4);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_instr"}, instruction_out, 32'h0);
    chk({tag, "_pc"}, pc_out, 32'h0);
    chk({tag, "_pc4"}, pc_plus_4_out, 32'h0);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_req"}, 32'(mem.imem_req), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    mem.imem_gnt    = 1'b1;
    mem.imem_rvalid = 1'b0;
    mem.imem_rdata  = '0;

    cycle();
    cycle();
    chk_zero("rst");
    reset = 1'b0;
    #1;
    chk("rel_req", 32'(mem.imem_req), 32'd1);
    chk("rel_addr", mem.imem_addr, RESET_PC_DEF);

    // back-to-back fetches, one instruction every second cycle
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("seq_valid", 32'(valid_out), 32'(i % 2));
      if (i % 2 == 1)
        chk("seq_pc", pc_out, RESET_PC_DEF + 32'(4 * (i / 2)));
    end

    // stall across the response: outputs frozen, response parked
    ovr_addr = 32'h0040_000C;
    ovr_data = 32'h00A0_0093;
    chk("stl_addr", mem.imem_addr, 32'h0040_000C);
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("stl_valid", 32'(valid_out), 32'd1);
      chk("stl_pc", pc_out, 32'h0040_0008);
      chk("stl_instr", instruction_out, ~32'h0040_0008);
      chk("stl_req", 32'(mem.imem_req), 32'd0);
    end
    stall = 1'b0;
    cycle();
    chk("unstl_instr", instruction_out, 32'h00A0_0093);
    chk("unstl_req", 32'(mem.imem_req), 32'd1);
    chk("unstl_addr", mem.imem_addr, 32'h0040_0010);

    // redirect while waiting: flush, drop the late response
    lat = 3;
    cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0103;
    cycle();
    redirect = 1'b0;
    chk("rd_valid", 32'(valid_out), 32'd0);
    chk("rd_nop", instruction_out, NOP_INSTR_DEF);
    chk("rd_req0", 32'(mem.imem_req), 32'd0);
    cycle();
    chk("drop_req0", 32'(mem.imem_req), 32'd0);
    cycle();
    chk("drop_req1", 32'(mem.imem_req), 32'd1);
    chk("drop_addr", mem.imem_addr, 32'h0040_0100);
    chk("drop_valid", 32'(valid_out), 32'd0);
    lat = 1;
    cycle();
    cycle();
    chk("rd_tgt_pc", pc_out, 32'h0040_0100);

    // redirect on the response cycle under stall: no hold
    cycle();
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0200;
    cycle();
    redirect = 1'b0;
    chk("rdst_valid", 32'(valid_out), 32'd0);
    chk("rdst_nop", instruction_out, NOP_INSTR_DEF);
    chk("rdst_req", 32'(mem.imem_req), 32'd1);
    chk("rdst_addr", mem.imem_addr, 32'h0040_0200);
    stall = 1'b0;
    cycle();
    cycle();
    chk("rdst_pc", pc_out, 32'h0040_0200);

    // wrap at the top of the address space
    mem.imem_gnt = 1'b0;
    redirect     = 1'b1;
    redirect_pc  = 32'hFFFF_FFFE;
    cycle();
    redirect     = 1'b0;
    mem.imem_gnt = 1'b1;
    chk("wrap_req", 32'(mem.imem_req), 32'd1);
    chk("wrap_addr0", mem.imem_addr, 32'hFFFF_FFFC);
    cycle();
    cycle();
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus_4_out, 32'h0);
    chk("wrap_next", mem.imem_addr, 32'h0);

    // reset mid-request with a late response afterwards
    lat = 2;
    cycle();
    reset = 1'b1;
    cycle();
    chk_zero("mid_rst");
    reset = 1'b0;
    lat   = 1;
    #1;
    chk("late_rv", 32'(mem.imem_rvalid), 32'd1);
    chk("late_req", 32'(mem.imem_req), 32'd1);
    chk("late_addr", mem.imem_addr, RESET_PC_DEF);
    cycle();
    chk("late_valid", 32'(valid_out), 32'd0);
    chk("late_instr", instruction_out, 32'h0);
    cycle();
    chk("restart_pc", pc_out, RESET_PC_DEF);
    chk("restart_instr", instruction_out, ~RESET_PC_DEF);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
